// File: rtl/lock_pkg.sv
// Shared definitions for the encoded lock machine: digit geometry,
// decision-stage state encoding and the factory combination.
package lock_pkg;

    localparam int DIGIT_W    = 5;
    localparam int NUM_DIGITS = 3;

    typedef enum logic [1:0] {
        LOCKED  = 2'd0,
        COMPARE = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    localparam logic [DIGIT_W-1:0] DEF_CODE0 = 5'd1;
    localparam logic [DIGIT_W-1:0] DEF_CODE1 = 5'd2;
    localparam logic [DIGIT_W-1:0] DEF_CODE2 = 5'd3;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that times the lockout interval. It holds at zero
// and raises zero_o so the owner can decide when the interval has expired.
module lock_timer #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] count_q, count_d;

    // Next count: a load wins over counting; never decrement below zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/code_checker.sv
// Lock-decision stage: snapshots the three operand digits on CHECK, compares
// them one digit per cycle against the stored combination (always all three,
// so timing does not leak which digit was wrong), tracks consecutive
// failures and imposes a timed lockout once MAX_FAIL is reached.
module code_checker
    import lock_pkg::*;
#(
    parameter int                 MAX_FAIL       = 3,
    parameter int                 LOCKOUT_CYCLES = 1000,
    parameter logic [DIGIT_W-1:0] CODE0          = DEF_CODE0,
    parameter logic [DIGIT_W-1:0] CODE1          = DEF_CODE1,
    parameter logic [DIGIT_W-1:0] CODE2          = DEF_CODE2
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CHECK,
    input  logic               PROG,
    input  logic               CLR_LOCK,
    input  logic [DIGIT_W-1:0] opRead0,
    input  logic [DIGIT_W-1:0] opRead1,
    input  logic [DIGIT_W-1:0] opRead2,
    output logic               UNLOCKED,
    output logic               BUSY,
    output logic               FAIL,
    output logic               ALARM,
    output logic [2:0]         FAIL_CNT
);

    localparam int         TIMER_W    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [2:0] MAX_FAIL_C = 3'(MAX_FAIL);
    localparam logic [1:0] LAST_IDX   = 2'(NUM_DIGITS - 1);

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic               mismatch_q, mismatch_d;
    logic [2:0]         fail_cnt_q, fail_cnt_d;
    logic               fail_d;
    logic [DIGIT_W-1:0] snap_q [NUM_DIGITS];
    logic [DIGIT_W-1:0] snap_d [NUM_DIGITS];
    logic [DIGIT_W-1:0] code_q [NUM_DIGITS];
    logic [DIGIT_W-1:0] code_d [NUM_DIGITS];

    logic               unlocked_q, busy_q, fail_q, alarm_q;

    logic               digit_ne;
    logic               any_mismatch;
    logic [2:0]         cnt_inc;
    logic               timer_load;
    logic               timer_en;
    logic               timer_zero;
    logic [TIMER_W-1:0] timer_cnt;

    assign digit_ne     = (snap_q[idx_q] != code_q[idx_q]);
    assign any_mismatch = mismatch_q | digit_ne;
    assign cnt_inc      = (fail_cnt_q >= MAX_FAIL_C) ? MAX_FAIL_C : fail_cnt_q + 3'd1;
    assign timer_en     = (state_q == LOCKOUT) && (timer_cnt != '0);

    lock_timer #(
        .W (TIMER_W)
    ) u_lockout_timer (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .load_i     (timer_load),
        .load_val_i (TIMER_W'(LOCKOUT_CYCLES - 1)),
        .en_i       (timer_en),
        .count_o    (timer_cnt),
        .zero_o     (timer_zero)
    );

    // Next-state and datapath update for the lock FSM.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mismatch_d = mismatch_q;
        fail_cnt_d = fail_cnt_q;
        fail_d     = 1'b0;
        snap_d     = snap_q;
        code_d     = code_q;
        timer_load = 1'b0;

        case (state_q)
            LOCKED: begin
                if (CHECK) begin
                    snap_d[0]  = opRead0;
                    snap_d[1]  = opRead1;
                    snap_d[2]  = opRead2;
                    mismatch_d = 1'b0;
                    idx_d      = 2'd0;
                    state_d    = COMPARE;
                end
            end
            COMPARE: begin
                mismatch_d = any_mismatch;
                idx_d      = idx_q + 2'd1;
                if (idx_q == LAST_IDX) begin
                    idx_d = 2'd0;
                    if (!any_mismatch) begin
                        fail_cnt_d = 3'd0;
                        state_d    = OPEN;
                    end else begin
                        fail_d     = 1'b1;
                        fail_cnt_d = cnt_inc;
                        if (cnt_inc == MAX_FAIL_C) begin
                            timer_load = 1'b1;
                            state_d    = LOCKOUT;
                        end else begin
                            state_d    = LOCKED;
                        end
                    end
                end
            end
            OPEN: begin
                // Relock takes priority so a simultaneous PROG is discarded.
                if (CLR_LOCK) begin
                    state_d = LOCKED;
                end else if (PROG) begin
                    code_d[0] = opRead0;
                    code_d[1] = opRead1;
                    code_d[2] = opRead2;
                end
            end
            LOCKOUT: begin
                if (timer_zero) begin
                    fail_cnt_d = 3'd0;
                    state_d    = LOCKED;
                end
            end
            default: begin
                state_d = LOCKED;
            end
        endcase
    end

    // State, datapath and registered output flops.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= LOCKED;
            idx_q      <= 2'd0;
            mismatch_q <= 1'b0;
            fail_cnt_q <= 3'd0;
            snap_q     <= '{default: '0};
            code_q     <= '{CODE0, CODE1, CODE2};
            unlocked_q <= 1'b0;
            busy_q     <= 1'b0;
            fail_q     <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mismatch_q <= mismatch_d;
            fail_cnt_q <= fail_cnt_d;
            snap_q     <= snap_d;
            code_q     <= code_d;
            unlocked_q <= (state_d == OPEN);
            busy_q     <= (state_d == COMPARE);
            fail_q     <= fail_d;
            alarm_q    <= (state_d == LOCKOUT);
        end
    end

    assign UNLOCKED = unlocked_q;
    assign BUSY     = busy_q;
    assign FAIL     = fail_q;
    assign ALARM    = alarm_q;
    assign FAIL_CNT = fail_cnt_q;

endmodule
